// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/arb_picker.sv
// Grant selection between IFU (lane 0) and LSU (lane 1).
// ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise LSU has fixed priority.
module arb_picker (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_req
);

    assign any_req = |req;

`ifdef ARB_ROUND_ROBIN_EN
    // Contested cycle hands the bus to whichever lane did not win last time.
    assign grant = (req == 2'b11) ? ~last_grant : req[1];
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant = req[1];
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI read arbiter, one transaction outstanding.
// ARB_ROUND_ROBIN_EN enables round-robin arbitration (default: LSU fixed priority).
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            m_arvalid,
    output logic [1:0]            m_arready,
    input  logic [2*ADDR_W-1:0]   m_araddr,
    output logic [1:0]            m_rvalid,
    input  logic [1:0]            m_rready,
    output logic [2*DATA_W-1:0]   m_rdata,
    output logic [3:0]            m_rresp,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [ADDR_W-1:0]     s_araddr,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp
);

    arb_state_t        state_q, state_d;
    logic              grant_q;
    logic              pick;
    logic              any_req;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_buf;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (state_q == IDLE && any_req) begin
            last_grant_q <= pick;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = 1'b1;
`endif

    arb_picker u_picker (
        .req        (m_arvalid),
        .last_grant (last_grant),
        .grant      (pick),
        .any_req    (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            addr_buf <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                grant_q  <= pick;
                addr_buf <= pick ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        m_arready = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_rvalid  = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    m_arready[pick] = 1'b1;
                    state_d         = ADDR;
                end
            end
            ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_rvalid[grant_q] = s_rvalid;
                s_rready          = m_rready[grant_q];
                if (s_rvalid && m_rready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data and response fan out to both lanes; only m_rvalid says who owns them.
    assign s_araddr = addr_buf;
    assign m_rdata  = {2{s_rdata}};
    assign m_rresp  = {2{s_rresp}};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter; honours ARB_ROUND_ROBIN_EN in its reference model.
module tb_axi_rd_arbiter;
    import axi_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  m_arvalid;
    logic [1:0]  m_arready;
    logic [63:0] m_araddr;
    logic [1:0]  m_rvalid;
    logic [1:0]  m_rready;
    logic [63:0] m_rdata;
    logic [3:0]  m_rresp;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_araddr;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;

    int checks   = 0;
    int failures = 0;
    logic model_last;

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Arbitration rule: lone requester wins; contested goes to LSU, or alternates under round-robin.
    function automatic logic model_pick(input logic [1:0] req);
`ifdef ARB_ROUND_ROBIN_EN
        if (req == 2'b11) return ~model_last;
`endif
        return req[1];
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Full transaction starting in an IDLE cycle; ends one cycle after the R handshake.
    task automatic do_txn(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] rd, input logic [1:0] rs,
                          input int unsigned arw, input int unsigned rvw, input int unsigned rrw);
        logic        w;
        logic [1:0]  oh;
        logic [31:0] ea;
        w  = model_pick(req);
        oh = 2'b01 << w;
        ea = w ? a1 : a0;
        m_arvalid = req;
        m_araddr  = {a1, a0};
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        m_rready  = 2'b00;
        #1;
        checks++;
        if (m_arready !== oh) begin
            failures++;
            $display("FAIL ar_grant: m_arready=%b required=%b (req=%b)", m_arready, oh, req);
        end
        checks++;
        if (s_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL idle_s_arvalid: s_arvalid=%b required=0", s_arvalid);
        end
        model_last = w;
        for (int unsigned i = 0; i <= arw; i++) begin
            next_cycle();
            m_arvalid = 2'($urandom_range(0, 3));
            m_araddr  = {$urandom, $urandom};
            s_arready = (i == arw);
            #1;
            checks++;
            if (s_arvalid !== 1'b1 || s_araddr !== ea) begin
                failures++;
                $display("FAIL addr_phase: s_arvalid=%b s_araddr=%h required 1/%h", s_arvalid, s_araddr, ea);
            end
            checks++;
            if (m_arready !== 2'b00 || s_rready !== 1'b0 || m_rvalid !== 2'b00) begin
                failures++;
                $display("FAIL addr_quiet: m_arready=%b s_rready=%b m_rvalid=%b required 00/0/00", m_arready, s_rready, m_rvalid);
            end
        end
        for (int unsigned i = 0; i < rvw; i++) begin
            next_cycle();
            s_arready = 1'b0;
            s_rvalid  = 1'b0;
            m_rready  = 2'($urandom_range(0, 3));
            #1;
            checks++;
            if (s_arvalid !== 1'b0 || m_rvalid !== 2'b00 || s_rready !== m_rready[w]) begin
                failures++;
                $display("FAIL data_wait: s_arvalid=%b m_rvalid=%b s_rready=%b required 0/00/%b", s_arvalid, m_rvalid, s_rready, m_rready[w]);
            end
        end
        for (int unsigned i = 0; i <= rrw; i++) begin
            next_cycle();
            s_arready   = 1'b0;
            s_rvalid    = 1'b1;
            s_rdata     = rd;
            s_rresp     = rs;
            m_rready    = 2'($urandom_range(0, 3));
            m_rready[w] = (i == rrw);
            #1;
            checks++;
            if (m_rvalid !== oh || s_rready !== (i == rrw)) begin
                failures++;
                $display("FAIL r_route: m_rvalid=%b s_rready=%b required %b/%b", m_rvalid, s_rready, oh, (i == rrw));
            end
            checks++;
            if (m_rdata !== {rd, rd} || m_rresp !== {rs, rs}) begin
                failures++;
                $display("FAIL r_payload: m_rdata=%h m_rresp=%b required %h/%b", m_rdata, m_rresp, {rd, rd}, {rs, rs});
            end
        end
        next_cycle();
        s_rvalid  = 1'b0;
        m_rready  = 2'b00;
        m_arvalid = 2'b00;
        #1;
        checks++;
        if (m_rvalid !== 2'b00 || s_arvalid !== 1'b0 || s_rready !== 1'b0) begin
            failures++;
            $display("FAIL after_r: m_rvalid=%b s_arvalid=%b s_rready=%b required 00/0/0", m_rvalid, s_arvalid, s_rready);
        end
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        m_arvalid = 2'b00;
        m_rready  = 2'b00;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b0;
        model_last = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        apply_reset();
        s_rvalid = 1'b1;
        s_rdata  = 32'hCAFE_0001;
        m_rready = 2'b11;
        #1;
        checks++;
        if (m_arready !== 2'b00 || s_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ar: m_arready=%b s_arvalid=%b required 00/0", m_arready, s_arvalid);
        end
        checks++;
        if (m_rvalid !== 2'b00 || s_rready !== 1'b0) begin
            failures++;
            $display("FAIL reset_r: m_rvalid=%b s_rready=%b required 00/0", m_rvalid, s_rready);
        end
        next_cycle();
        s_rvalid = 1'b0;
        m_rready = 2'b00;
        #1;
    endtask

    task automatic test_ifu_single;
        apply_reset();
        do_txn(2'b01, 32'h0200_BFF8, 32'h1111_0000, 32'h1234_5678, RESP_OKAY, 0, 0, 0);
    endtask

    task automatic test_back_to_back;
        apply_reset();
        for (int k = 0; k < 6; k++)
            do_txn(2'b11, 32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k), $urandom, RESP_OKAY, 0, 0, 0);
    endtask

    task automatic test_stall;
        do_txn(2'b10, 32'h3000_0000, 32'h4000_0040, 32'hDEAD_BEEF, RESP_OKAY, 4, 0, 3);
    endtask

    task automatic test_slverr;
        do_txn(2'b01, 32'h0200_0004, 32'h0, 32'h0BAD_0BAD, RESP_SLVERR, 1, 2, 0);
    endtask

    task automatic test_reset_mid;
        m_arvalid = 2'b01;
        m_araddr  = {32'h5555_0000, 32'h6666_0000};
        model_last = 1'b0;
        next_cycle();
        m_arvalid = 2'b00;
        s_arready = 1'b1;
        next_cycle();
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = 32'h7777_8888;
        m_rready  = 2'b11;
        #1;
        checks++;
        if (m_rvalid !== 2'b01) begin
            failures++;
            $display("FAIL mid_data: m_rvalid=%b required 01", m_rvalid);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (m_rvalid !== 2'b00 || s_rready !== 1'b0 || s_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: m_rvalid=%b s_rready=%b s_arvalid=%b required 00/0/0", m_rvalid, s_rready, s_arvalid);
        end
        model_last = 1'b1;
        s_rvalid = 1'b0;
        m_rready = 2'b00;
        do_txn(2'b11, 32'hA000_0000, 32'hB000_0000, 32'h0F0F_F0F0, RESP_OKAY, 0, 0, 0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 25; k++)
            do_txn(2'($urandom_range(1, 3)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 1) ? RESP_SLVERR : RESP_OKAY,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    initial begin
        rst       = 1'b1;
        m_arvalid = 2'b00;
        m_araddr  = '0;
        m_rready  = 2'b00;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = RESP_OKAY;
        model_last = 1'b1;
        test_reset();
        test_ifu_single();
        test_back_to_back();
        test_stall();
        test_slverr();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of every AR channel.
REQ-002 SHALL have parameter DATA_W, default 32, data width of every R channel.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port m_arvalid  input  2  per-master AR valid; bit0 = IFU, bit1 = LSU.
REQ-006 SHALL have port m_arready  output  2  per-master AR ready.
REQ-007 SHALL have port m_araddr  input  2*ADDR_W  per-master address; lane i = bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port m_rvalid  output  2  per-master R valid.
REQ-009 SHALL have port m_rready  input  2  per-master R ready.
REQ-010 SHALL have port m_rdata  output  2*DATA_W  per-master read data.
REQ-011 SHALL have port m_rresp  output  4  per-master read response, 2 bits per lane.
REQ-012 SHALL have ports s_arvalid/s_arready/s_araddr  output/input/output  1/1/ADDR_W  slave AR channel (CLINT or memory).
REQ-013 SHALL have ports s_rvalid/s_rready/s_rdata/s_rresp  input/output/input/input  1/1/DATA_W/2  slave R channel.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, DATA; one read transaction outstanding at a time.
REQ-015 In IDLE with any m_arvalid bit set, SHALL pick one grant, assert m_arready[grant] combinationally that cycle, latch grant and m_araddr lane into addr_buf, and go to ADDR.
REQ-016 In IDLE, m_arready SHALL be 1 only for the granted lane; it SHALL be 0 for both lanes in ADDR and DATA.
REQ-017 In ADDR, s_arvalid SHALL be 1 and s_araddr SHALL equal addr_buf; on s_arready = 1, SHALL go to DATA.
REQ-018 s_arvalid SHALL be 0 outside ADDR; the first s_arvalid appears exactly one cycle after the master AR handshake.
REQ-019 In DATA, m_rvalid[grant] SHALL equal s_rvalid, s_rready SHALL equal m_rready[grant], and the other m_rvalid bit SHALL be 0.
REQ-020 m_rdata and m_rresp lanes SHALL both carry s_rdata/s_rresp at all times; only m_rvalid qualifies.
REQ-021 On s_rvalid & s_rready in DATA, SHALL return to IDLE; a new grant is possible in that next IDLE cycle (minimum 3 cycles per transaction with a zero-wait slave).
REQ-022 s_rready SHALL be 0 outside DATA; an s_rvalid outside DATA SHALL be ignored.
REQ-023 m_arvalid changes in ADDR/DATA SHALL NOT affect grant or addr_buf.
REQ-024 Single requester SHALL always be granted regardless of priority state.

Reset
REQ-025 On rst, state SHALL become IDLE, grant 0, addr_buf 0, last_grant 1 at the next edge.
REQ-026 Reset mid-transaction SHALL abandon it; m_arready stays combinational per REQ-015 in the first post-reset cycle, s_arvalid, s_rready, m_rvalid SHALL be 0.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests SHALL grant the lane not equal to last_grant; last_grant updates on every IDLE grant.
REQ-028 Macro ARB_ROUND_ROBIN_EN undefined: SHALL give fixed priority to LSU (bit1); last_grant register omitted.

Structure
REQ-029 Package axi_arb_pkg SHALL hold the FSM enum type (arb_state_t) and RESP constants OKAY=2'b00, SLVERR=2'b10.
REQ-030 Grant selection SHALL live in one sub-module arb_picker (inputs: request bits, last_grant; output: grant index, any_req).

Verification
REQ-031 IFU-only read 0x0200_BFF8, zero-wait slave returns 0x1234_5678/OKAY -> m_arready=01 cycle 0, s_arvalid cycle 1, m_rvalid=01 with 0x1234_5678 cycle 2, m_rvalid=00 cycle 3.
REQ-032 Both request in same cycle, RR enabled, out of reset -> IFU granted first, LSU next transaction; repeat -> IFU, LSU alternate.
REQ-033 Both request, macro undefined -> LSU granted on every contested cycle; IFU waits with m_arvalid held.
REQ-034 Slave holds s_arready=0 for 4 cycles, LSU holds m_rready=0 for 3 cycles after s_rvalid -> s_araddr stable, s_rready=0 until LSU ready, single R handshake, data 0xDEAD_BEEF unchanged.
REQ-035 rst asserted in DATA with s_rvalid=1 -> next cycle state IDLE, m_rvalid=00, s_rready=0, last_grant=1.
REQ-036 Slave returns SLVERR for address 0x0200_0004 -> m_rresp lane of grant = 2'b10 with m_rvalid set.
